// File: rtl/noc_pkg.sv
// Shared ring-NoC types: coordinates, flit preamble, head-flit layout,
// injector FSM states and ring routing helpers.
package noc_pkg;

  // Ring geometry: tiles are numbered row-major into a single ring.
  localparam int x_max  = 8;
  localparam int y_max  = 8;
  localparam int CoordW = 3;

  // Default flit geometry shared by every port of the ring.
  localparam int NocFlitWidth    = 64;
  localparam int NocMaxBodyFlits = 4;
  localparam int NocLenW         = $clog2(NocMaxBodyFlits + 1);

  typedef enum logic [0:0] {
    kFlowControlValidReady  = 1'b0,
    kFlowControlCreditBased = 1'b1
  } flow_control_t;

  typedef struct packed {
    logic [CoordW-1:0] x;
    logic [CoordW-1:0] y;
  } xy_t;

  typedef logic [3:0] message_t;

  typedef enum logic [1:0] {
    goLocal = 2'd0,
    goEast  = 2'd1,
    goWest  = 2'd2
  } direction_t;

  typedef struct packed {
    logic head;
    logic tail;
  } preamble_t;

  // Bits used by header fields; the rest of the head flit is zero.
  localparam int HeadUsedW = 2 + 4 * CoordW + 2 + $bits(message_t) + NocLenW;

  typedef struct packed {
    preamble_t                         preamble;
    xy_t                               dst;
    xy_t                               src;
    direction_t                        route;
    message_t                          msg;
    logic [NocLenW-1:0]                len;
    logic [NocFlitWidth-HeadUsedW-1:0] fill;
  } noc_head_flit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } injector_state_t;

  // Position of a tile on the ring.
  function automatic int ring_index(xy_t p);
    return int'(p.y) * x_max + int'(p.x);
  endfunction

  // Shortest direction around the ring; an exact half-ring tie goes east.
  function automatic direction_t ring_route(xy_t src, xy_t dst);
    int n;
    int d;
    n = x_max * y_max;
    d = (ring_index(dst) - ring_index(src) + n) % n;
    if (d == 0)          return goLocal;
    else if (d <= n / 2) return goEast;
    else                 return goWest;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter for the injector: counts free slots in the router's local
// input buffer, saturates at the buffer depth and flags excess credits.
module noc_credit_counter
  import noc_pkg::*;
#(
  parameter  int Credits = 4,
  localparam int CntW    = $clog2(Credits + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            send,
  input  logic            credit_in,
  output logic [CntW-1:0] count,
  output logic            overflow
);

  logic [CntW-1:0] count_reg, count_next;
  logic            overflow_reg, overflow_next;

  // Next count: a send and a returned credit in the same cycle cancel out.
  always_comb begin
    count_next    = count_reg;
    overflow_next = overflow_reg;
    if (send && !credit_in) begin
      count_next = count_reg - CntW'(1);
    end else if (!send && credit_in) begin
      if (count_reg == CntW'(Credits)) overflow_next = 1'b1;
      else                             count_next    = count_reg + CntW'(1);
    end
  end

  // Counter starts full; the overflow flag is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg    <= CntW'(Credits);
      overflow_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/noc_flit_injector.sv
// Local-port transmitter: accepts one message from the tile, serializes it
// into head/body flits and pushes them into the router under credit control.
module noc_flit_injector
  import noc_pkg::*;
#(
  parameter  int FlitWidth    = NocFlitWidth,
  parameter  int MaxBodyFlits = NocMaxBodyFlits,
  parameter  int Credits      = 4,
  localparam int PW           = FlitWidth - 2,
  localparam int LenW         = $clog2(MaxBodyFlits + 1),
  localparam int CntW         = $clog2(Credits + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  xy_t                        local_xy,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  xy_t                        req_dst,
  input  message_t                   req_msg,
  input  logic [LenW-1:0]            req_len,
  input  logic [MaxBodyFlits*PW-1:0] req_payload,
  output logic                       flit_valid,
  output logic [FlitWidth-1:0]       flit_out,
  input  logic                       credit_in,
  output logic [CntW-1:0]            credit_count,
  output logic                       credit_overflow
);

  injector_state_t           state_reg, state_next;
  xy_t                       dst_reg, dst_next;
  message_t                  msg_reg, msg_next;
  logic [LenW-1:0]           len_reg, len_next;
  logic [LenW-1:0]           idx_reg, idx_next;
  logic [MaxBodyFlits*PW-1:0] payload_reg, payload_next;

  logic                      send;
  logic [LenW-1:0]           req_len_clamped;
  logic [LenW-1:0]           last_idx;
  logic                      last_body;
  logic [PW-1:0]             body_word;
  noc_head_flit_t            head_flit;

  assign req_len_clamped = (req_len > LenW'(MaxBodyFlits)) ? LenW'(MaxBodyFlits) : req_len;
  assign req_ready       = (state_reg == IDLE);
  assign send            = (state_reg != IDLE) && (credit_count != '0);
  assign flit_valid      = send;
  assign last_idx        = len_reg - LenW'(1);
  assign last_body       = (idx_reg == last_idx);
  assign body_word       = payload_reg[idx_reg*PW +: PW];

  noc_credit_counter #(
    .Credits (Credits)
  ) u_credit (
    .clk       (clk),
    .rst_n     (rst_n),
    .send      (send),
    .credit_in (credit_in),
    .count     (credit_count),
    .overflow  (credit_overflow)
  );

  // State and message registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      dst_reg     <= '0;
      msg_reg     <= '0;
      len_reg     <= '0;
      idx_reg     <= '0;
      payload_reg <= '0;
    end else begin
      state_reg   <= state_next;
      dst_reg     <= dst_next;
      msg_reg     <= msg_next;
      len_reg     <= len_next;
      idx_reg     <= idx_next;
      payload_reg <= payload_next;
    end
  end

  // Next state: capture on accept, then advance one flit per credited send.
  always_comb begin
    state_next   = state_reg;
    dst_next     = dst_reg;
    msg_next     = msg_reg;
    len_next     = len_reg;
    idx_next     = idx_reg;
    payload_next = payload_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next   = HEAD;
          dst_next     = req_dst;
          msg_next     = req_msg;
          len_next     = req_len_clamped;
          idx_next     = '0;
          payload_next = req_payload;
        end
      end
      HEAD: begin
        if (send) state_next = (len_reg == '0) ? IDLE : BODY;
      end
      BODY: begin
        if (send) begin
          if (last_body) state_next = IDLE;
          else           idx_next   = idx_reg + LenW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Flit formatting; the bus is held at zero whenever nothing is sent.
  always_comb begin
    head_flit               = '0;
    head_flit.preamble.head = 1'b1;
    head_flit.preamble.tail = (len_reg == '0);
    head_flit.dst           = dst_reg;
    head_flit.src           = local_xy;
    head_flit.route         = ring_route(local_xy, dst_reg);
    head_flit.msg           = msg_reg;
    head_flit.len           = len_reg;
    flit_out                = '0;
    if (send) begin
      if (state_reg == HEAD) flit_out = head_flit;
      else                   flit_out = {1'b0, last_body, body_word};
    end
  end

endmodule

// File: doc/noc_flit_injector.md
# noc_flit_injector

Local-port transmitter for the ring NoC. Accepts one message per handshake (destination, message type, up to `MaxBodyFlits` payload words) from the tile. Serializes it into head, body and tail flits, and drives them into the router's local input port. Uses credit-based flow control (`kFlowControlCreditBased`); the router is the receiving end and returns one credit per freed buffer slot.

## Interface
- `FlitWidth`, 64: flit width in bits. The top 2 bits are `preamble_t`; the remaining `FlitWidth-2` bits are the payload word width (PW).
- `MaxBodyFlits`, 4: maximum body flits per packet. LenW = $clog2(MaxBodyFlits+1).
- `Credits`, 4: depth of the router's local input buffer, and the credit counter reset value.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `local_xy`  in  xy_t  this tile's coordinates; quasi-static.
- `req_valid`  in  1  message request.
- `req_ready`  out  1  block is idle and can accept a message.
- `req_dst`  in  xy_t  destination coordinates.
- `req_msg`  in  message_t  message type.
- `req_len`  in  LenW  number of body flits; values above MaxBodyFlits are clamped.
- `req_payload`  in  MaxBodyFlits*PW  body words; word i is at [i*PW +: PW].
- `flit_valid`  out  1  a flit is transferred this cycle.
- `flit_out`  out  FlitWidth  flit data; all zeros when `flit_valid`=0.
- `credit_in`  in  1  one credit returned this cycle.
- `credit_count`  out  $clog2(Credits+1)  credits currently available.
- `credit_overflow`  out  1  sticky error flag: a credit was returned while the counter was at `Credits`.

## Operation
- FSM states: IDLE, HEAD, BODY.
  - IDLE→HEAD when `req_valid`&&`req_ready`. On this transition the block registers dst, msg, clamped len and payload, and clears the body index.
  - HEAD→IDLE when the head flit is sent and len=0.
  - HEAD→BODY when the head flit is sent and len>0.
  - BODY stays in BODY while the body index < len-1, incrementing the index on each sent flit.
  - BODY→IDLE when the flit with body index = len-1 is sent.
- `req_ready` = (state==IDLE).
- Send condition: `flit_valid` = (state!=IDLE) && (credit_count!=0).
- Head flit layout, MSB to LSB:
  - preamble {head=1, tail=(len==0)}
  - dst xy_t
  - src xy_t (`local_xy`)
  - direction_t route
  - message_t
  - len (LenW bits)
  - zero fill
- Route computation:
  - Ring index idx = y*xMax + x; N = xMax*yMax.
  - d = (idx_dst - idx_src) mod N.
  - d=0 → goLocal.
  - d ≤ N/2 → goEast; a tie at exactly N/2 goes east.
  - d > N/2 → goWest.
- Body flit i: preamble {0, i==len-1}, followed by payload word i.
- Credit counter:
  - −1 on `flit_valid`; +1 on `credit_in`.
  - Both in the same cycle: unchanged.
  - `credit_in` at `Credits` with no send that cycle: count holds at `Credits` and `credit_overflow` is set until reset.
  - The counter cannot underflow, because sending requires count>0.

## Timing
- Reset values:
  - state IDLE, so `req_ready`=1.
  - `flit_valid`=0, `flit_out`=0.
  - `credit_count`=`Credits`.
  - `credit_overflow`=0.
  - All message registers 0.
- Outputs depend only on registered state. There is no combinational path from `req_*` or `credit_in` to `flit_*`.
- Message accepted at edge T: the head flit is valid during cycle T+1, given credits. Body flits follow one per cycle while credits are available.
- Latency for a packet of len L with ample credits: L+1 cycles of `flit_valid`. `req_ready` rises the cycle after the tail flit. Back-to-back messages therefore have one bubble cycle.
- A credit returned in cycle C enables a send no earlier than cycle C+1.
- Reset asserted mid-packet: the packet is abandoned and all state returns to reset values asynchronously. The router is reset in the same domain, so no credit reconciliation is needed.

## Structure
- Add to the shared `noc` package:
  - `noc_head_flit_t` packed struct (head flit fields above).
  - `injector_state_t` enum.
  - function `ring_index(xy_t)`.
  - function `ring_route(xy_t src, xy_t dst)` returning direction_t.
- One sub-module: `noc_credit_counter`, holding the counter, saturation logic and overflow flag. Parameter: `Credits`.

## Test plan
- Single-flit packet: `local_xy`=(x1,y0), dst=(x3,y0), msg=5, len=0. Required: exactly one flit at T+1 with preamble 2'b11, route goEast, msg 5, len 0; `req_ready` returns to 1 at T+2.
- Credit starvation: `Credits`=2, len=3, no `credit_in`. Required: head and body0 sent, then `flit_valid`=0 with `credit_count`=0. Pulse `credit_in` once; body1 is sent the next cycle. A further credit sends body2 with preamble 2'b01.
- Routing (xMax=yMax=8, local (0,0)):
  - dst (7,7), d=63 → goWest.
  - dst (0,4), d=32 → goEast (tie).
  - dst (0,0) → goLocal.
- Simultaneous send and `credit_in` at count 1: count stays 1 and streaming continues without a gap.
- Overflow: idle with count=`Credits`, pulse `credit_in`. Required: count stays at `Credits`, `credit_overflow`=1 and remains set.
- Reset mid-BODY of a len=4 packet: `flit_valid`=0 immediately, `credit_count`=`Credits`, `req_ready`=1. The next accepted message starts cleanly with a head flit.
